// File: rtl/noise_gate.sv
// Output noise gate: envelope follower with hysteresis FSM and click-free gain ramp.
// Optional feature macro: GATE_BYPASS_EN adds a 'bypass' input that passes samples through.
module noise_gate #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned THRESH_OPEN  = 512,
    parameter int unsigned THRESH_CLOSE = 256,
    parameter int unsigned HOLD_SAMPLES = 2048,
    parameter int unsigned ENV_SHIFT    = 4,
    parameter int unsigned ATTACK_STEP  = 8,
    parameter int unsigned RELEASE_STEP = 1
) (
    input  logic                    sample_clock,
    input  logic                    reset,
`ifdef GATE_BYPASS_EN
    input  logic                    bypass,
`endif
    input  logic signed [WIDTH-1:0] input_sample,
    output logic signed [WIDTH-1:0] output_sample,
    output logic                    gate_open,
    output logic [2:0]              gate_state
);

    localparam logic [2:0] CLOSED  = 3'd0;
    localparam logic [2:0] ATTACK  = 3'd1;
    localparam logic [2:0] OPEN    = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam int unsigned HOLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam logic [WIDTH-1:0]  OPEN_LVL  = WIDTH'(THRESH_OPEN);
    localparam logic [WIDTH-1:0]  CLOSE_LVL = WIDTH'(THRESH_CLOSE);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);
    localparam logic [9:0]        ATK_STEP  = 10'(ATTACK_STEP);
    localparam logic [8:0]        REL_STEP  = 9'(RELEASE_STEP);
    localparam logic [8:0]        GAIN_FULL = 9'd256;

    logic [WIDTH-1:0]        mag, env_q, env_d, env_dec;
    logic [8:0]              gain_q, gain_d;
    logic [9:0]              gain_up;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [2:0]              state_q, state_d;
    logic signed [WIDTH-1:0] out_q, out_d, gated;
    logic signed [WIDTH+9:0] product;
    logic                    open_hit, close_hit;

    // Magnitude saturates the single unrepresentable case (most negative value).
    always_comb begin
        mag = input_sample;
        if (input_sample[WIDTH-1]) begin
            if (input_sample == {1'b1, {(WIDTH-1){1'b0}}}) begin
                mag = {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                mag = ~input_sample + 1'b1;
            end
        end
    end

    always_comb begin
        env_dec = env_q >> ENV_SHIFT;
        if (env_dec == '0) begin
            env_dec = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        env_d = env_q;
        if (mag > env_q) begin
            env_d = mag;
        end else if (env_q != '0) begin
            env_d = env_q - env_dec;
        end
    end

    assign open_hit  = (env_q >= OPEN_LVL);
    assign close_hit = (env_q < CLOSE_LVL);
    assign gain_up   = {1'b0, gain_q} + ATK_STEP;

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        case (state_q)
            CLOSED: begin
                gain_d = '0;
                if (open_hit) state_d = ATTACK;
            end
            ATTACK: begin
                gain_d = (gain_up >= {1'b0, GAIN_FULL}) ? GAIN_FULL : gain_up[8:0];
                if (gain_d == GAIN_FULL) state_d = OPEN;
            end
            OPEN: begin
                gain_d = GAIN_FULL;
                if (close_hit) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            HOLD: begin
                gain_d = GAIN_FULL;
                if (open_hit) begin
                    state_d = OPEN;
                end else if (hold_q == '0) begin
                    state_d = RELEASE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            RELEASE: begin
                gain_d = (gain_q > REL_STEP) ? gain_q - REL_STEP : '0;
                // Retrigger keeps the current gain so the re-attack ramps without a jump.
                if (open_hit) begin
                    state_d = ATTACK;
                end else if (gain_d == '0) begin
                    state_d = CLOSED;
                end
            end
            default: begin
                state_d = CLOSED;
                gain_d  = '0;
            end
        endcase
    end

    assign product = input_sample * $signed({1'b0, gain_q});
    assign gated   = WIDTH'(product >>> 8);

`ifdef GATE_BYPASS_EN
    assign out_d = bypass ? input_sample : gated;
`else
    assign out_d = gated;
`endif

    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            env_q   <= '0;
            gain_q  <= '0;
            hold_q  <= '0;
            state_q <= CLOSED;
            out_q   <= '0;
        end else begin
            env_q   <= env_d;
            gain_q  <= gain_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign output_sample = out_q;
    assign gate_state    = state_q;
    assign gate_open     = (state_q != CLOSED);

endmodule

// File: tb/tb_noise_gate.sv
// Scoreboard bench for noise_gate: a reference model pushes expected outputs per sample.
// Exercises the bypass path too when GATE_BYPASS_EN is defined.
module tb_noise_gate;

    logic               sample_clock = 1'b0;
    logic               reset;
    logic signed [15:0] input_sample;
    logic signed [15:0] output_sample;
    logic               gate_open;
    logic [2:0]         gate_state;
`ifdef GATE_BYPASS_EN
    logic               bypass;
`endif

    noise_gate dut (
        .sample_clock  (sample_clock),
        .reset         (reset),
`ifdef GATE_BYPASS_EN
        .bypass        (bypass),
`endif
        .input_sample  (input_sample),
        .output_sample (output_sample),
        .gate_open     (gate_open),
        .gate_state    (gate_state)
    );

    always #5 sample_clock = ~sample_clock;

    typedef struct {
        int out;
        int st;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_env, m_gain, m_hold, m_state, m_bypass;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_env = 0; m_gain = 0; m_hold = 0; m_state = 0;
        sb_q.delete();
    endtask

    // Reference model: next state from pre-edge env/gain; output from pre-edge gain.
    task automatic model_step(input int x);
        int a, d, ns, ng, nh;
        exp_t e;
        e.out = (m_bypass != 0) ? x : ((x * m_gain) >>> 8);
        ns = m_state; ng = m_gain; nh = m_hold;
        case (m_state)
            0: begin ng = 0; if (m_env >= 512) ns = 1; end
            1: begin
                ng = (m_gain + 8 > 256) ? 256 : m_gain + 8;
                if (ng == 256) ns = 2;
            end
            2: begin ng = 256; if (m_env < 256) begin ns = 3; nh = 2047; end end
            3: begin
                ng = 256;
                if (m_env >= 512) ns = 2;
                else if (m_hold == 0) ns = 4;
                else nh = m_hold - 1;
            end
            4: begin
                ng = (m_gain > 1) ? m_gain - 1 : 0;
                if (m_env >= 512) ns = 1;
                else if (ng == 0) ns = 0;
            end
            default: begin ns = 0; ng = 0; end
        endcase
        e.st = ns;
        sb_q.push_back(e);
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a > m_env) m_env = a;
        else if (m_env > 0) begin
            d = m_env >> 4;
            if (d < 1) d = 1;
            m_env = m_env - d;
        end
        m_state = ns; m_gain = ng; m_hold = nh;
    endtask

    task automatic do_cycle(input int x);
        exp_t e;
        input_sample = 16'(x);
        model_step(x);
        @(posedge sample_clock);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check_eq("out", int'(output_sample), e.out);
            check_eq("state", int'(gate_state), e.st);
            check_eq("open", int'(gate_open), int'(e.st != 0));
        end
    endtask

    initial begin
        int seen_a, seen_h, seen_r, amp, x;
        bit hit;
        reset = 1'b1;
        input_sample = '0;
        m_bypass = 0;
`ifdef GATE_BYPASS_EN
        bypass = 1'b0;
`endif
        model_reset();
        #12;
        check_eq("rst_out", int'(output_sample), 0);
        check_eq("rst_state", int'(gate_state), 0);
        check_eq("rst_open", int'(gate_open), 0);
        reset = 1'b0;

        // Silence keeps the gate shut.
        for (int i = 0; i < 100; i++) do_cycle(0);
        check_eq("silent_closed", int'(gate_state), 0);

        // Loud constant opens through a 32-edge attack.
        seen_a = 0;
        for (int i = 1; i <= 40; i++) begin
            do_cycle(4096);
            if (i == 2) check_eq("attack_edge2", int'(gate_state), 1);
            if (gate_state == 3'd1) seen_a++;
        end
        check_eq("attack_len", seen_a, 32);
        check_eq("open_pass", int'(output_sample), 4096);

        // Quiet tail: hold then release to closed.
        seen_h = 0; seen_r = 0;
        for (int i = 0; i < 3000; i++) begin
            do_cycle(100);
            if (gate_state == 3'd3) seen_h++;
            if (gate_state == 3'd4) seen_r++;
        end
        check_eq("hold_len", seen_h, 2048);
        check_eq("release_len", seen_r, 256);
        check_eq("tail_closed", int'(gate_state), 0);
        check_eq("tail_out", int'(output_sample), 0);

        // Full-scale extremes pass exactly when open.
        for (int i = 0; i < 40; i++) do_cycle(4096);
        do_cycle(-32768);
        check_eq("neg_full", int'(output_sample), -32768);
        do_cycle(32767);
        check_eq("pos_full", int'(output_sample), 32767);

        // Retrigger during release at gain 128 ramps up from there.
        hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            if (m_state == 4 && m_gain == 128) hit = 1'b1;
            else do_cycle(100);
        end
        check_eq("reach_rel128", int'(hit), 1);
        do_cycle(4096);
        do_cycle(4096);
        check_eq("retrig_attack", int'(gate_state), 1);
        do_cycle(4096);
        do_cycle(4096);
        check_eq("retrig_ramp", int'(output_sample), 16 * 134);
        do_cycle(4096);

        // Asynchronous reset mid-attack takes effect before the next edge.
        #2 reset = 1'b1;
        #1;
        check_eq("arst_out", int'(output_sample), 0);
        check_eq("arst_state", int'(gate_state), 0);
        check_eq("arst_open", int'(gate_open), 0);
        @(posedge sample_clock);
        #1 reset = 1'b0;
        model_reset();

`ifdef GATE_BYPASS_EN
        bypass = 1'b1;
        m_bypass = 1;
        for (int i = 0; i < 20; i++) do_cycle(int'($urandom_range(0, 400)) - 200);
        bypass = 1'b0;
        m_bypass = 0;
`endif

        // Random bursts of varying loudness.
        for (int s = 0; s < 12; s++) begin
            case (s % 5)
                0: amp = 0;
                1: amp = 50;
                2: amp = 300;
                3: amp = 2000;
                default: amp = 32768;
            endcase
            for (int i = 0; i < 60; i++) begin
                x = int'($urandom_range(0, 2 * amp)) - amp;
                if (x > 32767) x = 32767;
                do_cycle(x);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
